// File: rtl/l_func_operand_tx.sv
// rtl/l_func_operand_tx.sv - L-function operand transmitter: x-1 borrow chain, operand buffer, start/burst sender
module l_func_operand_tx #(
  parameter int N     = 4096,
  parameter int M     = 2048,
  parameter int Block = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Block-1:0] src_x,
  input  logic [Block-1:0] src_n,
  input  logic             src_valid,
  input  logic             src_last,
  output logic             src_ready,
  output logic [Block-1:0] dividend_out,
  output logic [Block-1:0] divisor_out,
  output logic             valid_out,
  output logic             data_vld_out,
  input  logic             div_done_in,
  output logic             busy,
  output logic             underflow,
  output logic             frame_err
);

  localparam int NCNT = N / Block;
  localparam int MCNT = M / Block;
  localparam int CW   = $clog2(NCNT + 1);
  localparam int AW   = (NCNT > 1) ? $clog2(NCNT) : 1;
  localparam int MAW  = (MCNT > 1) ? $clog2(MCNT) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCNT - 1);
  localparam logic [CW-1:0] NCNT_C   = CW'(NCNT);
  localparam logic [CW-1:0] MCNT_C   = CW'(MCNT);

  typedef enum logic [2:0] {IDLE, LOAD, START, SEND, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    rd_q, rd_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             underflow_q, underflow_d;
  logic             frame_err_q, frame_err_d;
  logic             valid_q, valid_d;
  logic             dvld_q, dvld_d;
  logic [Block-1:0] div_q, div_d;
  logic [Block-1:0] dvs_q, dvs_d;

  logic [Block-1:0] mem_x [NCNT];
  logic [Block-1:0] mem_n [MCNT];

  logic             accept;
  logic             wr_en;
  logic             borrow_nx;
  logic             last_beat;
  logic [Block-1:0] x_dec;
  logic [Block-1:0] rd_x;
  logic [Block-1:0] rd_n;

  assign src_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept    = src_valid && src_ready;
  assign x_dec     = src_x - {{(Block-1){1'b0}}, borrow_q};
  assign borrow_nx = (src_x == '0) && borrow_q;
  assign last_beat = (cnt_q == LAST_IDX);
  assign rd_x      = mem_x[rd_q[AW-1:0]];
  assign rd_n      = mem_n[rd_q[MAW-1:0]];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    borrow_d    = borrow_q;
    busy_d      = busy_q;
    underflow_d = underflow_q;
    frame_err_d = frame_err_q;
    valid_d     = 1'b0;
    dvld_d      = 1'b0;
    div_d       = div_q;
    dvs_d       = dvs_q;
    wr_en       = 1'b0;

    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          wr_en    = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          borrow_d = borrow_nx;
          busy_d   = 1'b1;
          if (state_q == IDLE) begin
            underflow_d = 1'b0;
            frame_err_d = src_last && !last_beat;
          end else if (src_last && !last_beat) begin
            frame_err_d = 1'b1;
          end
          if (last_beat || src_last) begin
            state_d     = START;
            valid_d     = 1'b1;
            underflow_d = borrow_nx;
            rd_d        = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      START, SEND: begin
        // Beats past the loaded count are the zero fill, minus any pending borrow.
        if (rd_q < NCNT_C) begin
          state_d = SEND;
          dvld_d  = 1'b1;
          div_d   = (rd_q < cnt_q) ? rd_x : {Block{borrow_q}};
          dvs_d   = ((rd_q < cnt_q) && (rd_q < MCNT_C)) ? rd_n : '0;
          rd_d    = rd_q + 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (div_done_in) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          cnt_d    = '0;
          rd_d     = '0;
          borrow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      borrow_q    <= 1'b1;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
      valid_q     <= 1'b0;
      dvld_q      <= 1'b0;
      div_q       <= '0;
      dvs_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      borrow_q    <= borrow_d;
      busy_q      <= busy_d;
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
      valid_q     <= valid_d;
      dvld_q      <= dvld_d;
      div_q       <= div_d;
      dvs_q       <= dvs_d;
    end
  end

  // Operand buffers carry no reset; only beats below cnt_q are ever read back.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_x[cnt_q[AW-1:0]] <= x_dec;
      if (cnt_q < MCNT_C) begin
        mem_n[cnt_q[MAW-1:0]] <= src_n;
      end
    end
  end

  assign dividend_out = div_q;
  assign divisor_out  = dvs_q;
  assign valid_out    = valid_q;
  assign data_vld_out = dvld_q;
  assign busy         = busy_q;
  assign underflow    = underflow_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_l_func_operand_tx.sv
// tb/tb_l_func_operand_tx.sv - scoreboard bench for l_func_operand_tx
module tb_l_func_operand_tx;

  localparam int N     = 4096;
  localparam int M     = 2048;
  localparam int Block = 128;
  localparam int NCNT  = N / Block;
  localparam int MCNT  = M / Block;

  typedef struct {
    logic [Block-1:0] d;
    logic [Block-1:0] s;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [Block-1:0] src_x = '0;
  logic [Block-1:0] src_n = '0;
  logic             src_valid = 1'b0;
  logic             src_last = 1'b0;
  logic             src_ready;
  logic [Block-1:0] dividend_out;
  logic [Block-1:0] divisor_out;
  logic             valid_out;
  logic             data_vld_out;
  logic             div_done_in = 1'b0;
  logic             busy;
  logic             underflow;
  logic             frame_err;

  int vecs = 0;
  int miss = 0;

  exp_t sb[$];
  logic exp_uf;
  logic drv_to;

  logic [Block-1:0] cap_d [NCNT];
  logic [Block-1:0] cap_s [NCNT];
  logic             cap_v [NCNT];
  logic             c_vo, c_dv0, c_after, c_vo_burst;

  l_func_operand_tx #(.N(N), .M(M), .Block(Block)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_x        (src_x),
    .src_n        (src_n),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .dividend_out (dividend_out),
    .divisor_out  (divisor_out),
    .valid_out    (valid_out),
    .data_vld_out (data_vld_out),
    .div_done_in  (div_done_in),
    .busy         (busy),
    .underflow    (underflow),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Pushes the expected burst, then drives beats 0..last_beat; returns just after the final accepting edge.
  task automatic drive_frame(input logic [N-1:0] x, input logic [N-1:0] n, input int last_beat, input bit stall);
    logic [N-1:0] xt;
    logic [N-1:0] xm1;
    exp_t e;
    int k;
    int cyc;
    bit tog;
    bit acc;
    xt = x;
    for (int j = last_beat + 1; j < NCNT; j++) xt[j*Block +: Block] = '0;
    xm1 = xt - 1;
    exp_uf = (xt == '0);
    for (int j = 0; j < NCNT; j++) begin
      e.d = xm1[j*Block +: Block];
      e.s = (j < MCNT && j <= last_beat) ? n[j*Block +: Block] : '0;
      sb.push_back(e);
    end
    k = 0; cyc = 0; tog = 1'b0; drv_to = 1'b0;
    while (k <= last_beat && cyc < 4 * NCNT) begin
      @(negedge clk);
      src_valid = stall ? tog : 1'b1;
      tog = !tog;
      src_x = x[k*Block +: Block];
      src_n = (k < MCNT) ? n[k*Block +: Block] : {$urandom, $urandom, $urandom, $urandom};
      src_last = (k == last_beat);
      acc = src_valid && src_ready;
      @(posedge clk);
      if (acc) k++;
      cyc++;
    end
    if (k <= last_beat) drv_to = 1'b1;
    #1;
    src_valid = 1'b0;
    src_last = 1'b0;
  endtask

  task automatic capture_burst();
    @(negedge clk);
    c_vo = valid_out;
    c_dv0 = data_vld_out;
    c_vo_burst = 1'b0;
    for (int j = 0; j < NCNT; j++) begin
      @(negedge clk);
      cap_v[j] = data_vld_out;
      cap_d[j] = dividend_out;
      cap_s[j] = divisor_out;
      c_vo_burst = c_vo_burst | valid_out;
    end
    @(negedge clk);
    c_after = data_vld_out;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    div_done_in = 1'b1;
    @(negedge clk);
    div_done_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vecs++;
    if ({dividend_out, divisor_out, valid_out, data_vld_out, busy, underflow, frame_err} !== '0) begin
      miss++;
      $display("FAIL reset_outputs: got div=%h dvs=%h v=%b dv=%b busy=%b uf=%b fe=%b, want all 0",
               dividend_out, divisor_out, valid_out, data_vld_out, busy, underflow, frame_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (src_ready !== 1'b1 || busy !== 1'b0) begin
      miss++;
      $display("FAIL reset_idle: got ready=%b busy=%b, want 1 0", src_ready, busy);
    end
  endtask

  task automatic test_x_one();
    logic [N-1:0] x;
    logic [N-1:0] n;
    exp_t e;
    x = '0; x[0] = 1'b1;
    n = '0; n[1:0] = 2'b11;
    drive_frame(x, n, NCNT - 1, 1'b0);
    capture_burst();
    vecs++;
    if (drv_to || c_vo !== 1'b1 || c_dv0 !== 1'b0 || c_after !== 1'b0 || c_vo_burst !== 1'b0) begin
      miss++;
      $display("FAIL x_one_timing: got to=%b vo=%b dv0=%b after=%b vo_burst=%b, want 0 1 0 0 0",
               drv_to, c_vo, c_dv0, c_after, c_vo_burst);
    end
    for (int j = 0; j < NCNT; j++) begin
      e = sb.pop_front();
      vecs++;
      if (cap_v[j] !== 1'b1 || cap_d[j] !== e.d || cap_s[j] !== e.s) begin
        miss++;
        $display("FAIL x_one beat %0d: got v=%b d=%h s=%h, want d=%h s=%h", j, cap_v[j], cap_d[j], cap_s[j], e.d, e.s);
      end
    end
    vecs++;
    if (underflow !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b1 || src_ready !== 1'b0) begin
      miss++;
      $display("FAIL x_one_wait: got uf=%b fe=%b busy=%b ready=%b, want 0 0 1 0", underflow, frame_err, busy, src_ready);
    end
    repeat (3) @(negedge clk);
    vecs++;
    if (busy !== 1'b1 || data_vld_out !== 1'b0) begin
      miss++;
      $display("FAIL x_one_hold: got busy=%b dv=%b, want 1 0", busy, data_vld_out);
    end
    pulse_done();
    vecs++;
    if (busy !== 1'b0 || src_ready !== 1'b1) begin
      miss++;
      $display("FAIL x_one_done: got busy=%b ready=%b, want 0 1", busy, src_ready);
    end
  endtask

  task automatic test_borrow();
    logic [N-1:0] x;
    exp_t e;
    x = '0; x[Block] = 1'b1;
    drive_frame(x, rand_wide(), NCNT - 1, 1'b0);
    capture_burst();
    vecs++;
    if (drv_to || c_vo !== 1'b1 || c_after !== 1'b0) begin
      miss++;
      $display("FAIL borrow_timing: got to=%b vo=%b after=%b, want 0 1 0", drv_to, c_vo, c_after);
    end
    for (int j = 0; j < NCNT; j++) begin
      e = sb.pop_front();
      vecs++;
      if (cap_v[j] !== 1'b1 || cap_d[j] !== e.d || cap_s[j] !== e.s) begin
        miss++;
        $display("FAIL borrow beat %0d: got v=%b d=%h s=%h, want d=%h s=%h", j, cap_v[j], cap_d[j], cap_s[j], e.d, e.s);
      end
    end
    vecs++;
    if (underflow !== 1'b0) begin
      miss++;
      $display("FAIL borrow_uf: got %b, want 0", underflow);
    end
    pulse_done();
  endtask

  task automatic test_zero();
    exp_t e;
    drive_frame('0, rand_wide(), NCNT - 1, 1'b0);
    @(negedge clk);
    vecs++;
    if (underflow !== 1'b1 || valid_out !== 1'b1) begin
      miss++;
      $display("FAIL zero_uf_start: got uf=%b vo=%b, want 1 1", underflow, valid_out);
    end
    for (int j = 0; j < NCNT; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      vecs++;
      if (data_vld_out !== 1'b1 || dividend_out !== e.d || divisor_out !== e.s) begin
        miss++;
        $display("FAIL zero beat %0d: got v=%b d=%h s=%h, want d=%h s=%h", j, data_vld_out, dividend_out, divisor_out, e.d, e.s);
      end
    end
    pulse_done();
    @(negedge clk);
    src_valid = 1'b1;
    src_x = 128'h5;
    src_last = 1'b0;
    @(negedge clk);
    src_valid = 1'b0;
    vecs++;
    if (underflow !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b1) begin
      miss++;
      $display("FAIL zero_uf_clear: got uf=%b fe=%b busy=%b, want 0 0 1", underflow, frame_err, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stall();
    exp_t e;
    drive_frame(rand_wide(), rand_wide(), NCNT - 1, 1'b1);
    capture_burst();
    vecs++;
    if (drv_to || c_vo !== 1'b1 || c_dv0 !== 1'b0 || c_after !== 1'b0) begin
      miss++;
      $display("FAIL stall_timing: got to=%b vo=%b dv0=%b after=%b, want 0 1 0 0", drv_to, c_vo, c_dv0, c_after);
    end
    for (int j = 0; j < NCNT; j++) begin
      e = sb.pop_front();
      vecs++;
      if (cap_v[j] !== 1'b1 || cap_d[j] !== e.d || cap_s[j] !== e.s) begin
        miss++;
        $display("FAIL stall beat %0d: got v=%b d=%h s=%h, want d=%h s=%h", j, cap_v[j], cap_d[j], cap_s[j], e.d, e.s);
      end
    end
    vecs++;
    if (underflow !== exp_uf || frame_err !== 1'b0) begin
      miss++;
      $display("FAIL stall_flags: got uf=%b fe=%b, want %b 0", underflow, frame_err, exp_uf);
    end
    pulse_done();
  endtask

  task automatic test_early_last();
    logic [N-1:0] x;
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      x = rand_wide();
      x[0] = 1'b1;
      if (c == 1) x[6*Block-1:0] = '0;
      drive_frame(x, rand_wide(), 5, 1'b0);
      capture_burst();
      vecs++;
      if (drv_to || c_vo !== 1'b1 || c_after !== 1'b0) begin
        miss++;
        $display("FAIL early_timing case %0d: got to=%b vo=%b after=%b, want 0 1 0", c, drv_to, c_vo, c_after);
      end
      for (int j = 0; j < NCNT; j++) begin
        e = sb.pop_front();
        vecs++;
        if (cap_v[j] !== 1'b1 || cap_d[j] !== e.d || cap_s[j] !== e.s) begin
          miss++;
          $display("FAIL early case %0d beat %0d: got v=%b d=%h s=%h, want d=%h s=%h", c, j, cap_v[j], cap_d[j], cap_s[j], e.d, e.s);
        end
      end
      vecs++;
      if (frame_err !== 1'b1 || underflow !== exp_uf) begin
        miss++;
        $display("FAIL early_flags case %0d: got fe=%b uf=%b, want 1 %b", c, frame_err, underflow, exp_uf);
      end
      pulse_done();
    end
  endtask

  task automatic test_reset_mid_send();
    drive_frame(rand_wide(), rand_wide(), NCNT - 1, 1'b0);
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      div_done_in = (j == 3);
    end
    vecs++;
    if (busy !== 1'b1 || data_vld_out !== 1'b1) begin
      miss++;
      $display("FAIL send_done_ignored: got busy=%b dv=%b, want 1 1", busy, data_vld_out);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({dividend_out, divisor_out, valid_out, data_vld_out, busy, underflow, frame_err} !== '0) begin
      miss++;
      $display("FAIL mid_reset_outputs: got div=%h dvs=%h v=%b dv=%b busy=%b, want all 0",
               dividend_out, divisor_out, valid_out, data_vld_out, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    vecs++;
    if (src_ready !== 1'b1 || busy !== 1'b0 || data_vld_out !== 1'b0) begin
      miss++;
      $display("FAIL mid_reset_idle: got ready=%b busy=%b dv=%b, want 1 0 0", src_ready, busy, data_vld_out);
    end
  endtask

  initial begin
    test_reset();
    test_x_one();
    test_borrow();
    test_zero();
    test_stall();
    test_early_last();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
